regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WE3/AD3/WD3) between two writeback sources.
- Source 1 is the in-order pipeline writeback (high priority, never buffered).
- Source 2 is the long-latency load/store unit, buffered in a FIFO.
- Sits between the writeback stage / LSU and the register file; the write-port outputs are registered.
- Starvation guard forces an LSU write after a bounded wait.

Parameters:
- FIFO_DEPTH, 4, LSU writeback buffer entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go unserved before forced service
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  pipeline writeback request
- pipe_ready  out  1  pipeline request accepted this cycle
- pipe_rd  in  ADDR_W  pipeline destination register
- pipe_wd  in  DATA_W  pipeline write data
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  FIFO can accept (= !full)
- lsu_rd  in  ADDR_W  LSU destination register
- lsu_wd  in  DATA_W  LSU write data
- rf_we  out  1  register-file write enable (to WE3)
- rf_ad  out  ADDR_W  register-file write address (to AD3)
- rf_wd  out  DATA_W  register-file write data (to WD3)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- pending_mask  out  32  registers with an outstanding write (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO flushed; fifo_count=0.
  - rf_we=0, rf_ad=0, rf_wd=0.
  - starve_cnt=0; state=ST_NORMAL.
  - Buffered LSU writes are lost.
- LSU push: on the rising edge where lsu_valid && lsu_ready, write {lsu_rd, lsu_wd} at the tail.
  - lsu_ready is derived from registered occupancy only: full blocks a push even if a pop occurs in the same cycle.
- FSM: ST_NORMAL, ST_FORCE.
  - ST_NORMAL:
    - pipe_ready=1; a pipeline request wins.
    - If pipe_valid=0 and FIFO non-empty, pop the head.
    - starve_cnt increments on each cycle with FIFO non-empty and no pop; it clears on a pop or when the FIFO is empty.
    - When starve_cnt reaches STARVE_LIMIT-1 with FIFO still unserved, go to ST_FORCE.
  - ST_FORCE:
    - pipe_ready=0; pop the head unconditionally.
    - starve_cnt=0; return to ST_NORMAL next cycle.
    - Exactly one forced pop per entry into ST_FORCE.
- Output stage: the selected write is registered. rf_we/rf_ad/rf_wd are valid the cycle after acceptance/pop.
  - Pipeline latency: 1 cycle.
  - LSU latency: minimum 2 cycles (push edge, pop edge).
- x0 writes: accepted/popped normally (handshake completes), but rf_we=0 for that cycle; rf_ad/rf_wd hold their previous values.
- No write selected: rf_we=0 next cycle; rf_ad/rf_wd hold.
- Simultaneous push and pop: allowed when not full; fifo_count is unchanged.
- Pointer wrap: modulo FIFO_DEPTH, with an extra pointer bit used to distinguish full from empty.
- Ordering: LSU writes retire in FIFO order. Pipeline vs LSU ordering to the same register is the issuing logic's responsibility (use pending_mask).

Optional Feature:
- Macro: REGFILE_WB_SCOREBOARD_EN.
- Defined: pending_mask[r]=1 (for r != 0) while any valid FIFO entry targets r, or the output stage holds rf_we=1 with rf_ad=r.
  - Combinational OR over FIFO entries plus the output stage.
  - Bit 0 is always 0.
- Undefined: pending_mask tied to 32'b0 and no scoreboard logic is built.

Decomposition:
- Package regfile_wb_pkg:
  - typedef wb_req_t {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] wd;}
  - enum arb_state_t {ST_NORMAL, ST_FORCE}
  - localparam REG_ZERO=5'd0
- Sub-module wb_fifo: synchronous FIFO with async-high reset; ports push/pop/full/empty/count, plus an entry-vector export for the scoreboard. The arbiter FSM and output register stay in the top module.

Test Plan:
- Pipe only: pipe_valid=1, rd=5, wd=0xDEADBEEF at cycle 0 -> rf_we=1, rf_ad=5, rf_wd=0xDEADBEEF at cycle 1; pipe_ready stays 1.
- LSU only: push rd=10, wd=0x1234 at cycle 0 -> fifo_count=1 at cycle 1, then 0 at cycle 2; rf_we=1, rf_ad=10 at cycle 2.
- Full FIFO: 4 pushes while pipe_valid is held high -> lsu_ready=0 after the 4th push.
- Starvation: pipe_valid held high continuously -> after STARVE_LIMIT=8 cycles, pipe_ready=0 for exactly one cycle; the FIFO head is written the following cycle; fifo_count drops to 3.
- x0 write: pipe rd=0, wd=0xFFFFFFFF -> pipe_ready=1, and rf_we=0 on the next cycle.
- Reset mid-operation: assert rst with fifo_count=3 and ST_FORCE pending -> immediately rf_we=0, fifo_count=0, lsu_ready=1, pipe_ready=1 after release.
- Scoreboard (macro defined): push rd=7 -> pending_mask=32'h80 until the cycle after rf_we for rd=7; with the macro undefined, pending_mask stays 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic {ST_NORMAL, ST_FORCE} arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// LSU writeback buffer: pointer-based FIFO, extra pointer bit separates full from empty.
// Entry export ports exist only when REGFILE_WB_SCOREBOARD_EN is defined.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
`ifdef REGFILE_WB_SCOREBOARD_EN
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            entry_valid,
`endif
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [DEPTH-1:0][AW-1:0] slot_off;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    entries = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i]    = AW'(i) - rd_ptr_q[AW-1:0];
      entry_valid[i] = ({1'b0, slot_off[i]} < count);
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline and buffered LSU writebacks.
// Define REGFILE_WB_SCOREBOARD_EN to build the pending_mask scoreboard.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_valid,
  output logic                         pipe_ready,
  input  logic [ADDR_W-1:0]            pipe_rd,
  input  logic [DATA_W-1:0]            pipe_wd,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [ADDR_W-1:0]            lsu_rd,
  input  logic [DATA_W-1:0]            lsu_wd,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_ad,
  output logic [DATA_W-1:0]            rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [31:0]                  pending_mask
);
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam int RW = ADDR_W + DATA_W;

  arb_state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_ad_q, rf_ad_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic fifo_pop, fifo_full, fifo_empty;
  logic [RW-1:0] fifo_head;
  logic sel_valid;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_wd;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [FIFO_DEPTH-1:0][RW-1:0] fifo_entries;
  logic [FIFO_DEPTH-1:0]         fifo_entry_valid;
`endif

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (lsu_valid),
    .pop         (fifo_pop),
    .wdata       ({lsu_rd, lsu_wd}),
    .rdata       (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
`ifdef REGFILE_WB_SCOREBOARD_EN
    .entries     (fifo_entries),
    .entry_valid (fifo_entry_valid),
`endif
    .count       (fifo_count)
  );

  assign lsu_ready = !fifo_full;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pipe_ready = 1'b0;
    fifo_pop   = 1'b0;
    sel_valid  = 1'b0;
    sel_rd     = pipe_rd;
    sel_wd     = pipe_wd;
    case (state_q)
      ST_NORMAL: begin
        pipe_ready = 1'b1;
        if (pipe_valid) begin
          sel_valid = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          sel_valid        = 1'b1;
          {sel_rd, sel_wd} = fifo_head;
        end
        if (fifo_empty || fifo_pop) begin
          starve_d = '0;
        end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
          starve_d = '0;
          state_d  = ST_FORCE;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      ST_FORCE: begin
        fifo_pop         = !fifo_empty;
        sel_valid        = !fifo_empty;
        {sel_rd, sel_wd} = fifo_head;
        starve_d         = '0;
        state_d          = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
    // x0 writes complete the handshake but never reach the register file.
    rf_we_d = sel_valid && (sel_rd != ADDR_W'(REG_ZERO));
    rf_ad_d = rf_we_d ? sel_rd : rf_ad_q;
    rf_wd_d = rf_we_d ? sel_wd : rf_wd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_ad_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_ad_q  <= rf_ad_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_ad = rf_ad_q;
  assign rf_wd = rf_wd_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifo_entry_valid[i]) pending_mask[fifo_entries[i][RW-1:DATA_W]] = 1'b1;
    if (rf_we_q) pending_mask[rf_ad_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end
`else
  assign pending_mask = 32'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, lsu_valid;
  logic        pipe_ready, lsu_ready;
  logic [4:0]  pipe_rd, lsu_rd;
  logic [31:0] pipe_wd, lsu_wd;
  logic        rf_we;
  logic [4:0]  rf_ad;
  logic [31:0] rf_wd;
  logic [2:0]  fifo_count;
  logic [31:0] pending_mask;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: LSU queue, unserved-cycle count, forced-service flag, write-port image.
  wb_req_t     q[$];
  int          wait_n;
  bit          force_pend;
  bit          m_we;
  logic [4:0]  m_ad;
  logic [31:0] m_wd;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .rf_we(rf_we), .rf_ad(rf_ad), .rf_wd(rf_wd),
    .fifo_count(fifo_count), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = '0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (m_we) m[m_ad] = 1'b1;
    m[0] = 1'b0;
`endif
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    wait_n     = 0;
    force_pend = 1'b0;
    m_we       = 1'b0;
    m_ad       = '0;
    m_wd       = '0;
  endtask

  // One clock edge: apply the arbitration rules to the inputs present at the edge.
  task automatic tick();
    bit      wr;
    bit      can_push;
    wb_req_t w;
    @(posedge clk);
    can_push = (q.size() < DEPTH);
    wr = 1'b0;
    w  = '0;
    if (force_pend) begin
      w = q.pop_front();
      wr = 1'b1;
      force_pend = 1'b0;
      wait_n = 0;
    end else if (pipe_valid) begin
      w.rd = pipe_rd;
      w.wd = pipe_wd;
      wr = 1'b1;
      if (q.size() > 0) begin
        wait_n++;
        if (wait_n == LIMIT) begin
          force_pend = 1'b1;
          wait_n = 0;
        end
      end else wait_n = 0;
    end else if (q.size() > 0) begin
      w = q.pop_front();
      wr = 1'b1;
      wait_n = 0;
    end else wait_n = 0;
    if (lsu_valid && can_push) q.push_back(wb_req_t'({lsu_rd, lsu_wd}));
    m_we = wr && (w.rd != 5'd0);
    if (m_we) begin
      m_ad = w.rd;
      m_wd = w.wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe_valid = 1'b0; lsu_valid = 1'b0;
    pipe_rd = '0; pipe_wd = '0; lsu_rd = '0; lsu_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", rf_we); end
    n_vec++; if (rf_ad !== 5'd0) begin n_err++; $display("FAIL reset_ad: got %h want 0", rf_ad); end
    n_vec++; if (rf_wd !== 32'd0) begin n_err++; $display("FAIL reset_wd: got %h want 0", rf_wd); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready); end
    n_vec++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
    rst = 1'b0;
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL reset_pipe_ready: got %b want 1", pipe_ready); end
  endtask

  task automatic test_pipe_only();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL pipe_ready: got %b want 1", pipe_ready); end
    tick();
    pipe_valid = 1'b0;
    n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL pipe_we: got %b want 1", rf_we); end
    n_vec++; if (rf_ad !== 5'd5) begin n_err++; $display("FAIL pipe_ad: got %0d want 5", rf_ad); end
    n_vec++; if (rf_wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL pipe_wd: got %h want deadbeef", rf_wd); end
    n_vec++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL pipe_mask: got %h want %h", pending_mask, exp_mask()); end
  endtask

  task automatic test_x0();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hFFFFFFFF;
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", pipe_ready); end
    tick();
    pipe_valid = 1'b0;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we: got %b want 0", rf_we); end
    n_vec++; if (rf_ad !== 5'd5) begin n_err++; $display("FAIL x0_ad_hold: got %0d want 5", rf_ad); end
    n_vec++; if (rf_wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL x0_wd_hold: got %h want deadbeef", rf_wd); end
  endtask

  task automatic test_lsu_only();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'h1234;
    tick();
    lsu_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL lsu_count1: got %0d want 1", fifo_count); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL lsu_we_early: got %b want 0", rf_we); end
    n_vec++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL lsu_mask1: got %h want %h", pending_mask, exp_mask()); end
    tick();
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL lsu_count2: got %0d want 0", fifo_count); end
    n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL lsu_we: got %b want 1", rf_we); end
    n_vec++; if (rf_ad !== 5'd10) begin n_err++; $display("FAIL lsu_ad: got %0d want 10", rf_ad); end
    n_vec++; if (rf_wd !== 32'h1234) begin n_err++; $display("FAIL lsu_wd: got %h want 1234", rf_wd); end
    n_vec++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL lsu_mask2: got %h want %h", pending_mask, exp_mask()); end
    tick();
    n_vec++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL lsu_mask3: got %h want %h", pending_mask, exp_mask()); end
  endtask

  task automatic test_full_starve();
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h0BAD_F00D;
    for (int i = 0; i < DEPTH; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(7 + i); lsu_wd = 32'hA000 + i;
      tick();
    end
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    n_vec++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", lsu_ready); end
    lsu_rd = 5'd20; lsu_wd = 32'hEEEE;
    tick();
    lsu_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_blocked: got %0d want 4", fifo_count); end
    // First push landed on tick 1, so ticks 2..9 are the unserved cycles.
    for (int t = 6; t <= 9; t++) begin
      tick();
      n_vec++; if (pipe_ready !== (t != 9)) begin n_err++; $display("FAIL starve_ready_t%0d: got %b want %b", t, pipe_ready, (t != 9)); end
    end
    tick();
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL force_once: got %b want 1", pipe_ready); end
    n_vec++; if (rf_we !== 1'b1 || rf_ad !== 5'd7) begin n_err++; $display("FAIL force_ad: got we=%b ad=%0d want we=1 ad=7", rf_we, rf_ad); end
    n_vec++; if (rf_wd !== 32'hA000) begin n_err++; $display("FAIL force_wd: got %h want a000", rf_wd); end
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL force_count: got %0d want 3", fifo_count); end
  endtask

  task automatic test_reset_mid();
    int  budget;
    budget = 0;
    while (!force_pend && budget < 20) begin
      tick();
      budget++;
    end
    n_vec++; if (!force_pend) begin n_err++; $display("FAIL mid_force_timeout: got none want force within 20"); end
    n_vec++; if (pipe_ready !== 1'b0 || fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_pre: got ready=%b count=%0d want ready=0 count=3", pipe_ready, fifo_count); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL mid_we: got %b want 0", rf_we); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL mid_lsu_ready: got %b want 1", lsu_ready); end
    pipe_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL mid_pipe_ready: got %b want 1", pipe_ready); end
  endtask

  task automatic test_random();
    int bias;
    for (int n = 0; n < 600; n++) begin
      bias = ((n / 150) % 2 == 1) ? 92 : 35;
      pipe_valid = ($urandom_range(99) < bias);
      lsu_valid  = ($urandom_range(99) < 55);
      pipe_rd    = 5'($urandom_range(31));
      pipe_wd    = $urandom;
      lsu_rd     = 5'($urandom_range(31));
      lsu_wd     = $urandom;
      tick();
      n_vec++; if (rf_we !== m_we) begin n_err++; $display("FAIL rnd_we @%0d: got %b want %b", n, rf_we, m_we); end
      n_vec++; if (rf_ad !== m_ad) begin n_err++; $display("FAIL rnd_ad @%0d: got %0d want %0d", n, rf_ad, m_ad); end
      n_vec++; if (rf_wd !== m_wd) begin n_err++; $display("FAIL rnd_wd @%0d: got %h want %h", n, rf_wd, m_wd); end
      n_vec++; if (fifo_count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, fifo_count, q.size()); end
      n_vec++; if (lsu_ready !== (q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_lsu_ready @%0d: got %b want %b", n, lsu_ready, (q.size() < DEPTH)); end
      n_vec++; if (pipe_ready !== !force_pend) begin n_err++; $display("FAIL rnd_pipe_ready @%0d: got %b want %b", n, pipe_ready, !force_pend); end
      n_vec++; if (pending_mask !== exp_mask()) begin n_err++; $display("FAIL rnd_mask @%0d: got %h want %h", n, pending_mask, exp_mask()); end
    end
    pipe_valid = 1'b0;
    lsu_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pipe_only();
    test_x0();
    test_lsu_only();
    test_full_starve();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
